// File: rtl/target_locator.sv
// rtl/target_locator.sv - resolves which scanned station holds the IR-commanded colour
//
// Ports:
//   clk, rst          clock and asynchronous active-high reset
//   start, abort      begin/restart a search; return to IDLE from any state
//   ir_valid/ir_color decoded IR colour command
//   scan_valid/color  one station colour per valid cycle, in station order 1..NUM_POS
//   target_color      latched commanded colour
//   target_pos        matched station 1..NUM_POS, 0 = none
//   drive_go          one-cycle drive start pulse
//   route_req         route request to the motor path
//   busy, done, fail  status (done/fail held until the next start)
//   state             current state code
module target_locator #(
  parameter int COLOR_W        = 2,
  parameter int NUM_POS        = 3,
  parameter int POS_W          = 2,
  parameter int CLEAR_CODE     = 0,
  parameter int TIMEOUT_CYC    = 1000000,
  parameter int TO_W           = 20,
  parameter int MAX_RETRY      = 1,
  parameter int ROUTE_W        = 3,
  parameter int ROUTE_STRAIGHT = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               abort,
  input  logic               ir_valid,
  input  logic [COLOR_W-1:0] ir_color,
  input  logic               scan_valid,
  input  logic [COLOR_W-1:0] scan_color,
  output logic [COLOR_W-1:0] target_color,
  output logic [POS_W-1:0]   target_pos,
  output logic               drive_go,
  output logic [ROUTE_W-1:0] route_req,
  output logic               busy,
  output logic               done,
  output logic               fail,
  output logic [2:0]         state
);

  localparam int IDX_W = (NUM_POS > 1) ? $clog2(NUM_POS) : 1;
  localparam int RT_W  = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

  localparam logic [COLOR_W-1:0] CLEAR    = COLOR_W'(CLEAR_CODE);
  localparam logic [ROUTE_W-1:0] STRAIGHT = ROUTE_W'(ROUTE_STRAIGHT);
  localparam logic [TO_W-1:0]    TO_LIM   = TO_W'(TIMEOUT_CYC);
  localparam logic [IDX_W-1:0]   LAST_IDX = IDX_W'(NUM_POS - 1);
  localparam logic [RT_W-1:0]    RT_MAX   = RT_W'(MAX_RETRY);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_IR_WAIT = 3'd1,
    S_DRIVE   = 3'd2,
    S_SCAN    = 3'd3,
    S_MATCH   = 3'd4,
    S_DONE    = 3'd5,
    S_FAIL    = 3'd6
  } state_t;

  state_t             state_q;
  logic [IDX_W-1:0]   idx;
  logic [RT_W-1:0]    retry;
  logic [TO_W-1:0]    to_cnt;
  logic [COLOR_W-1:0] slots [NUM_POS];

  logic [TO_W-1:0]    to_inc;
  logic               to_hit;
  logic               match_found;
  logic [IDX_W-1:0]   match_idx;

  assign state = state_q;
  assign busy  = (state_q == S_IR_WAIT) || (state_q == S_DRIVE) ||
                 (state_q == S_SCAN)    || (state_q == S_MATCH);

  // Watchdog fires on the cycle the count would reach the limit, so FAIL is
  // entered exactly TIMEOUT_CYC cycles after the count was last cleared.
  assign to_inc = to_cnt + 1'b1;
  assign to_hit = (TIMEOUT_CYC != 0) && (to_inc == TO_LIM);

  // Scan from the top down so the lowest matching slot is the one that sticks.
  always_comb begin
    match_found = 1'b0;
    match_idx   = '0;
    for (int i = NUM_POS - 1; i >= 0; i--) begin
      if (slots[i] == target_color) begin
        match_found = 1'b1;
        match_idx   = IDX_W'(i);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      target_color <= CLEAR;
      target_pos   <= '0;
      drive_go     <= 1'b0;
      route_req    <= '0;
      done         <= 1'b0;
      fail         <= 1'b0;
      idx          <= '0;
      retry        <= '0;
      to_cnt       <= '0;
      for (int i = 0; i < NUM_POS; i++) slots[i] <= '0;
    end else if (abort) begin
      state_q      <= S_IDLE;
      target_color <= CLEAR;
      target_pos   <= '0;
      drive_go     <= 1'b0;
      route_req    <= '0;
      done         <= 1'b0;
      fail         <= 1'b0;
      idx          <= '0;
      retry        <= '0;
      to_cnt       <= '0;
      for (int i = 0; i < NUM_POS; i++) slots[i] <= '0;
    end else begin
      drive_go <= 1'b0;
      case (state_q)
        S_IDLE, S_DONE, S_FAIL: begin
          if (start) begin
            state_q    <= S_IR_WAIT;
            done       <= 1'b0;
            fail       <= 1'b0;
            target_pos <= '0;
            retry      <= '0;
            to_cnt     <= '0;
          end
        end
        S_IR_WAIT: begin
          if (ir_valid && (ir_color != CLEAR)) begin
            target_color <= ir_color;
            state_q      <= S_DRIVE;
            drive_go     <= 1'b1;
            route_req    <= STRAIGHT;
          end else if (to_hit) begin
            state_q    <= S_FAIL;
            fail       <= 1'b1;
            target_pos <= '0;
            route_req  <= '0;
          end else begin
            to_cnt <= to_inc;
          end
        end
        S_DRIVE: begin
          idx     <= '0;
          to_cnt  <= '0;
          state_q <= S_SCAN;
        end
        S_SCAN: begin
          if (scan_valid) begin
            slots[idx] <= scan_color;
            to_cnt     <= '0;
            if (idx == LAST_IDX) state_q <= S_MATCH;
            else                 idx     <= idx + 1'b1;
          end else if (to_hit) begin
            state_q    <= S_FAIL;
            fail       <= 1'b1;
            target_pos <= '0;
            route_req  <= '0;
          end else begin
            to_cnt <= to_inc;
          end
        end
        S_MATCH: begin
          if (match_found) begin
            target_pos <= POS_W'(match_idx) + POS_W'(1);
            done       <= 1'b1;
            route_req  <= '0;
            state_q    <= S_DONE;
          end else if (retry < RT_MAX) begin
            // Rescan: re-enter DRIVE with a fresh drive_go pulse.
            retry    <= retry + 1'b1;
            drive_go <= 1'b1;
            state_q  <= S_DRIVE;
          end else begin
            target_pos <= '0;
            fail       <= 1'b1;
            route_req  <= '0;
            state_q    <= S_FAIL;
          end
        end
        default: begin
          state_q   <= S_IDLE;
          route_req <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_target_locator.sv
// tb/tb_target_locator.sv - directed self-checking bench for target_locator
module tb_target_locator;

  logic       clk;
  logic       rst;
  logic       start;
  logic       abort;
  logic       ir_valid;
  logic [1:0] ir_color;
  logic       scan_valid;
  logic [1:0] scan_color;
  logic [1:0] target_color;
  logic [1:0] target_pos;
  logic       drive_go;
  logic [2:0] route_req;
  logic       busy;
  logic       done;
  logic       fail;
  logic [2:0] state;

  int errors = 0;
  int checks = 0;

  target_locator #(
    .TIMEOUT_CYC(16),
    .TO_W(5)
  ) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .abort(abort),
    .ir_valid(ir_valid),
    .ir_color(ir_color),
    .scan_valid(scan_valid),
    .scan_color(scan_color),
    .target_color(target_color),
    .target_pos(target_pos),
    .drive_go(drive_go),
    .route_req(route_req),
    .busy(busy),
    .done(done),
    .fail(fail),
    .state(state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic scan3(input logic [1:0] c1, input logic [1:0] c2, input logic [1:0] c3);
    scan_valid = 1'b1;
    scan_color = c1; tick();
    scan_color = c2; tick();
    scan_color = c3; tick();
    scan_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; abort = 1'b0;
    ir_valid = 1'b0; ir_color = 2'd0; scan_valid = 1'b0; scan_color = 2'd0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state
    chk("rst_state", state, 0);
    chk("rst_tcolor", target_color, 0);
    chk("rst_tpos", target_pos, 0);
    chk("rst_drive_go", drive_go, 0);
    chk("rst_route", route_req, 0);
    chk("rst_done", done, 0);
    chk("rst_fail", fail, 0);
    chk("rst_busy", busy, 0);

    // Clear code ignored, then IR_WAIT watchdog
    start = 1'b1; tick(); start = 1'b0;
    chk("clr_enter_irw", state, 1);
    chk("clr_busy", busy, 1);
    ir_valid = 1'b1; ir_color = 2'd0;
    repeat (5) tick();
    ir_valid = 1'b0;
    chk("clr_still_irw", state, 1);
    chk("clr_tcolor", target_color, 0);
    repeat (10) tick();
    chk("to_before", state, 1);
    tick();
    chk("to_state", state, 6);
    chk("to_fail", fail, 1);
    chk("to_busy", busy, 0);
    start = 1'b1; tick(); start = 1'b0;
    chk("to_restart_state", state, 1);
    chk("to_restart_fail", fail, 0);

    // Basic match; stray scan_valid in IR_WAIT and start held in SCAN are ignored
    scan_valid = 1'b1; scan_color = 2'd2; tick(); scan_valid = 1'b0;
    chk("ign_scan_irw", state, 1);
    ir_valid = 1'b1; ir_color = 2'd2; tick(); ir_valid = 1'b0;
    chk("b_drive_state", state, 2);
    chk("b_drive_go", drive_go, 1);
    chk("b_route_drive", route_req, 1);
    chk("b_tcolor", target_color, 2);
    tick();
    chk("b_scan_state", state, 3);
    chk("b_drive_go_low", drive_go, 0);
    chk("b_route_scan", route_req, 1);
    start = 1'b1;
    scan_valid = 1'b1;
    scan_color = 2'd1; tick();
    chk("ign_start_scan", state, 3);
    scan_color = 2'd2; tick();
    chk("b_scan2_state", state, 3);
    scan_color = 2'd3; tick();
    scan_valid = 1'b0; start = 1'b0;
    chk("b_match_state", state, 4);
    chk("b_match_busy", busy, 1);
    chk("b_match_done", done, 0);
    tick();
    chk("b_done_state", state, 5);
    chk("b_done", done, 1);
    chk("b_tpos", target_pos, 2);
    chk("b_route_done", route_req, 0);
    chk("b_fail", fail, 0);
    tick();
    chk("b_done_held", done, 1);

    // Duplicate colour: lowest index wins
    start = 1'b1; tick(); start = 1'b0;
    chk("d_restart_done", done, 0);
    chk("d_restart_tpos", target_pos, 0);
    ir_valid = 1'b1; ir_color = 2'd3; tick(); ir_valid = 1'b0;
    tick();
    scan3(2'd3, 2'd1, 2'd3);
    tick();
    chk("d_state", state, 5);
    chk("d_tpos", target_pos, 1);

    // No match, rescan, no match again -> FAIL
    start = 1'b1; tick(); start = 1'b0;
    ir_valid = 1'b1; ir_color = 2'd2; tick(); ir_valid = 1'b0;
    chk("r_first_go", drive_go, 1);
    tick();
    scan3(2'd1, 2'd1, 2'd3);
    chk("r_match1", state, 4);
    tick();
    chk("r_redrive_state", state, 2);
    chk("r_second_go", drive_go, 1);
    chk("r_route_redrive", route_req, 1);
    tick();
    chk("r_rescan_state", state, 3);
    scan3(2'd3, 2'd3, 2'd1);
    tick();
    chk("r_fail_state", state, 6);
    chk("r_fail", fail, 1);
    chk("r_done", done, 0);
    chk("r_tpos", target_pos, 0);
    chk("r_route", route_req, 0);

    // Abort mid-SCAN after one station
    start = 1'b1; tick(); start = 1'b0;
    ir_valid = 1'b1; ir_color = 2'd1; tick(); ir_valid = 1'b0;
    tick();
    scan_valid = 1'b1; scan_color = 2'd1; tick(); scan_valid = 1'b0;
    chk("a_pre_state", state, 3);
    abort = 1'b1; tick(); abort = 1'b0;
    chk("a_state", state, 0);
    chk("a_tcolor", target_color, 0);
    chk("a_route", route_req, 0);
    chk("a_fail", fail, 0);
    chk("a_busy", busy, 0);

    // Asynchronous reset between edges during SCAN
    start = 1'b1; tick(); start = 1'b0;
    ir_valid = 1'b1; ir_color = 2'd3; tick(); ir_valid = 1'b0;
    tick();
    scan_valid = 1'b1; scan_color = 2'd2; tick(); scan_valid = 1'b0;
    chk("ar_pre_state", state, 3);
    chk("ar_pre_route", route_req, 1);
    #2 rst = 1'b1;
    #1;
    chk("ar_state", state, 0);
    chk("ar_tcolor", target_color, 0);
    chk("ar_route", route_req, 0);
    chk("ar_busy", busy, 0);
    tick();
    rst = 1'b0;
    tick();
    chk("ar_after_state", state, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/target_locator.md
Name: target_locator

Overview:
- Parametrised successor of the position-discovery FSM in the ThinkandMotor path.
- Takes an IR colour command and a streamed colour scan of NUM_POS stations, and resolves which station holds the commanded colour.
- Issues the drive request to the motor path and reports target position, done or fail.
- Adds over the prior generation: configurable station count and colour width, watchdog timeouts, bounded rescan retries, abort, and an explicit no-match/fail result.

Parameters:
- COLOR_W, 2, width of colour codes.
- NUM_POS, 3, number of stations scanned per pass (range 1..15).
- POS_W, 2, width of target_pos; must hold NUM_POS (1-based, 0 = none).
- CLEAR_CODE, 0, colour code meaning "no colour / clear"; never a valid target.
- TIMEOUT_CYC, 1000000, watchdog length in clk cycles for IR_WAIT and SCAN; 0 disables the watchdog.
- TO_W, 20, timeout counter width; must hold TIMEOUT_CYC.
- MAX_RETRY, 1, extra scan passes allowed after a no-match.
- ROUTE_W, 3, route request width.
- ROUTE_STRAIGHT, 1, route code driven while moving.

Ports:
- clk, in, 1, system clock.
- rst, in, 1, asynchronous active-high reset.
- start, in, 1, begin or restart a search (level-sampled).
- abort, in, 1, return to IDLE from any state.
- ir_valid, in, 1, ir_color is valid this cycle.
- ir_color, in, COLOR_W, decoded IR colour.
- scan_valid, in, 1, one station colour is presented this cycle.
- scan_color, in, COLOR_W, colour of the next station, in station order 1..NUM_POS.
- target_color, out, COLOR_W, latched commanded colour.
- target_pos, out, POS_W, matched station 1..NUM_POS; 0 = none.
- drive_go, out, 1, one-cycle drive start pulse.
- route_req, out, ROUTE_W, route request to the motor path.
- busy, out, 1, high in IR_WAIT, DRIVE, SCAN and MATCH.
- done, out, 1, match found (held).
- fail, out, 1, timeout or retries exhausted (held).
- state, out, 3, current state code.

Behaviour:
- Reset values (asynchronous): state=IDLE; target_color=CLEAR_CODE; target_pos=0; drive_go=0; route_req=0; done=0; fail=0. Internal scan index, retry count, timeout count and scan buffer are all cleared.
- All outputs are registered. busy is decoded from the state register.
- State codes: IDLE=0, IR_WAIT=1, DRIVE=2, SCAN=3, MATCH=4, DONE=5, FAIL=6. Codes 7 and above go to IDLE.
- Priority each cycle: abort > state logic. abort forces IDLE and clears outputs to their reset values (target_color included).
- IDLE:
  - start=1 -> IR_WAIT next cycle.
  - On that transition, clear done, fail, target_pos, retry count and timeout count.
- IR_WAIT:
  - ir_valid=1 and ir_color!=CLEAR_CODE -> latch target_color, go to DRIVE.
  - ir_valid with CLEAR_CODE is ignored.
  - The timeout count increments each cycle. When it reaches TIMEOUT_CYC (and TIMEOUT_CYC!=0), go to FAIL.
- DRIVE:
  - Lasts exactly 1 cycle. drive_go=1 in this cycle only.
  - route_req=ROUTE_STRAIGHT from this cycle until DONE, FAIL or IDLE, then it returns to 0.
  - Scan index and timeout count are cleared. Next state is SCAN.
- SCAN:
  - Each scan_valid cycle stores scan_color into slot[index], increments index, and clears the timeout count.
  - The cycle that stores slot NUM_POS-1 moves to MATCH.
  - scan_valid in any other state is ignored.
  - Timeout expiry (counted since the last scan_valid) goes to FAIL; slots already filled are discarded.
- MATCH (1 cycle):
  - The lowest-index slot equal to target_color wins: target_pos=index+1, next state DONE.
  - No match and retry count < MAX_RETRY: increment retry count, go to DRIVE (rescan, new drive_go pulse).
  - No match and retries exhausted: target_pos=0, go to FAIL.
- DONE: done=1 held; route_req=0. start=1 -> IR_WAIT with the clears listed under IDLE.
- FAIL: fail=1 held; route_req=0; target_pos=0. start restarts the search exactly as from DONE.
- Ignored inputs: start while busy is ignored. done and fail are never high simultaneously.
- Latency: ir accept -> drive_go takes 1 cycle. The last scan_valid -> done=1 takes 2 cycles (MATCH, then DONE registered).
- A reset asserted mid-operation takes effect immediately, regardless of clk, and restores all reset values.

Test Plan:
(All cases use defaults except TIMEOUT_CYC=16, TO_W=5.)
- Basic match: start; ir_color=2 valid; scans 1,2,3.
  -> drive_go one pulse, route_req=1 during scan, target_pos=2, done=1 two cycles after the last scan, route_req=0.
- Duplicate colour: ir_color=3; scans 3,1,3.
  -> target_pos=1 (lowest index wins).
- Retry then fail: ir_color=2; scans 1,1,3.
  -> rescan with a second drive_go pulse; scans 3,3,1 -> fail=1, target_pos=0, route_req=0.
- Clear and timeout: ir_color=0 offered for 5 cycles, then nothing.
  -> target_color stays 0; FAIL 16 cycles after entering IR_WAIT. start then re-enters IR_WAIT with fail=0.
- Abort and reset: abort mid-SCAN after 1 scan -> IDLE next cycle, all outputs at reset values.
  Separately, rst asserted between clk edges during SCAN -> outputs reset immediately.
- Ignored inputs: start held in SCAN, and scan_valid pulsed in IR_WAIT.
  -> neither has any effect on state or slots.
